// File: rtl/tx_arbitro.sv
// tx_arbitro: round-robin scheduler sharing one serial transmitter among
// N_REQ requesters; owns all frame timing (frame hold + inter-frame gap).
// Ports: clock, reset_n (async, active low); req/dado_in/instrucao_in from
// the sources; ack pulse back; botao/dado/instrucao to the transmitter;
// grant_id, ocupado, frames for status.
// Option: define TX_ARBITRO_PRIO0_EN to make requester 0 always win in IDLE.
module tx_arbitro #(
    parameter int N_REQ        = 4,
    parameter int FRAME_CYCLES = 16,
    parameter int GAP_CYCLES   = 2,
    parameter int IDW          = $clog2(N_REQ)
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [N_REQ-1:0]   req,
    input  logic [4*N_REQ-1:0] dado_in,
    input  logic [4*N_REQ-1:0] instrucao_in,
    output logic [N_REQ-1:0]   ack,
    output logic               botao,
    output logic [3:0]         dado,
    output logic [3:0]         instrucao,
    output logic [IDW-1:0]     grant_id,
    output logic               ocupado,
    output logic [7:0]         frames
);

    // One timer serves both the frame hold and the gap.
    localparam int TMAX = (FRAME_CYCLES > GAP_CYCLES) ?
                          FRAME_CYCLES : GAP_CYCLES;
    localparam int TW = $clog2(TMAX + 1);
    localparam logic [TW-1:0] F_END = TW'(FRAME_CYCLES - 1);
    localparam logic [TW-1:0] G_END =
        TW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [1:0] {IDLE, START, WAIT, GAP} state_t;

    state_t           state;
    logic [TW-1:0]    timer;
    logic [IDW-1:0]   ptr;
    logic [IDW-1:0]   win;
    logic [IDW-1:0]   cand;
    logic [IDW-1:0]   nxt;
    logic [IDW+1:0]   base;
    logic             hit;

    // First pending source at or after ptr, wrapping.
    always_comb begin
        win  = '0;
        hit  = 1'b0;
        cand = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = IDW'((int'(ptr) + k) % N_REQ);
            if (!hit && req[cand]) begin
                hit = 1'b1;
                win = cand;
            end
        end
`ifdef TX_ARBITRO_PRIO0_EN
        if (req[0]) win = '0;
`endif
    end

    assign nxt  = IDW'((int'(win) + 1) % N_REQ);
    assign base = {win, 2'b00};

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            timer     <= '0;
            ptr       <= '0;
            ack       <= '0;
            botao     <= 1'b0;
            dado      <= '0;
            instrucao <= '0;
            grant_id  <= '0;
            ocupado   <= 1'b0;
            frames    <= '0;
        end else begin
            ack   <= '0;
            botao <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (hit) begin
                        state     <= START;
                        botao     <= 1'b1;
                        ack       <= N_REQ'(1) << win;
                        dado      <= dado_in[base +: 4];
                        instrucao <= instrucao_in[base +: 4];
                        grant_id  <= win;
                        ocupado   <= 1'b1;
                        frames    <= frames + 8'd1;
                        ptr       <= nxt;
                    end
                end
                START: begin
                    state <= WAIT;
                    timer <= '0;
                end
                WAIT: begin
                    if (timer == F_END) begin
                        timer <= '0;
                        if (GAP_CYCLES == 0) begin
                            state   <= IDLE;
                            ocupado <= 1'b0;
                        end else begin
                            state <= GAP;
                        end
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                GAP: begin
                    if (timer == G_END) begin
                        timer   <= '0;
                        state   <= IDLE;
                        ocupado <= 1'b0;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tx_arbitro.sv
// tb_tx_arbitro: directed and random checks of tx_arbitro against a
// schedule-based model (frame start cycle, winner, captured operands).
module tb_tx_arbitro;

    localparam int N = 4;
    localparam int F = 16;
    localparam int G = 2;

    logic           clock = 1'b0;
    logic           reset_n = 1'b0;
    logic [N-1:0]   req = '0;
    logic [4*N-1:0] dado_in = '0;
    logic [4*N-1:0] instrucao_in = '0;
    logic [N-1:0]   ack;
    logic           botao;
    logic [3:0]     dado;
    logic [3:0]     instrucao;
    logic [1:0]     grant_id;
    logic           ocupado;
    logic [7:0]     frames;

    tx_arbitro #(
        .N_REQ(N), .FRAME_CYCLES(F), .GAP_CYCLES(G)
    ) dut (
        .clock(clock), .reset_n(reset_n), .req(req),
        .dado_in(dado_in), .instrucao_in(instrucao_in),
        .ack(ack), .botao(botao), .dado(dado),
        .instrucao(instrucao), .grant_id(grant_id),
        .ocupado(ocupado), .frames(frames)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    initial forever begin
        @(posedge clock);
        cyc++;
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // ---------------- model ----------------
    int         s_start = -1000;
    int         m_ptr = 0;
    int         m_w = 0;
    logic [3:0] m_d = '0;
    logic [3:0] m_i = '0;
    int         m_frames = 0;

    function automatic int pick(input logic [N-1:0] r, input int p);
`ifdef TX_ARBITRO_PRIO0_EN
        if (r[0]) return 0;
`endif
        for (int k = 0; k < N; k++)
            if (r[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    initial forever begin
        @(negedge clock);
        if (!reset_n) begin
            s_start = -1000; m_ptr = 0; m_w = 0;
            m_d = '0; m_i = '0; m_frames = 0;
        end
        begin
            bit busy;
            int w;
            busy = (cyc >= s_start) && (cyc <= s_start + F + G);
            chk("botao", botao, (cyc == s_start));
            chk("ack", ack, (cyc == s_start) ? (1 << m_w) : 0);
            chk("ocupado", ocupado, busy);
            chk("grant_id", grant_id, m_w);
            chk("dado", dado, m_d);
            chk("instrucao", instrucao, m_i);
            chk("frames", frames, m_frames);
            if (reset_n && !busy && req != 0) begin
                w = pick(req, m_ptr);
                s_start  = cyc + 1;
                m_w      = w;
                m_d      = dado_in[4*w +: 4];
                m_i      = instrucao_in[4*w +: 4];
                m_frames = (m_frames + 1) % 256;
                m_ptr    = (w + 1) % N;
            end
        end
    end

    // ---------------- stimulus ----------------
    int gq[$];
    int tq[$];

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset;
        reset_n = 1'b0;
        req = '0;
        tick;
        tick;
        reset_n = 1'b1;
    endtask

    task automatic collect(input int n, input logic [N-1:0] keep,
                           input int budget);
        gq.delete();
        tq.delete();
        for (int c = 0; c < budget && gq.size() < n; c++) begin
            tick;
            if (ack != 0) begin
                gq.push_back(int'(grant_id));
                tq.push_back(cyc);
                req = req & ~(ack & ~keep);
            end
        end
        chk("collect_count", gq.size(), n);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not end");
        $fatal(1);
    end

    initial begin
        int cnt;
        int f0;
        bit seen1;
        int exp_seq[8];
        int exp3[3];

        // reset state
        tick;
        chk("rst_ocupado", ocupado, 0);
        chk("rst_frames", frames, 0);
        do_reset;

        // single request
        dado_in[11:8] = 4'hA;
        instrucao_in[11:8] = 4'h3;
        req = 4'b0100;
        tick;
        chk("t1_ack", ack, 4'b0100);
        chk("t1_botao", botao, 1);
        chk("t1_dado", dado, 4'hA);
        chk("t1_instr", instrucao, 4'h3);
        chk("t1_gid", grant_id, 2);
        chk("t1_frames", frames, 1);
        req = '0;
        cnt = 1;
        for (int c = 0; c < 25; c++) begin
            tick;
            if (ocupado) cnt++;
        end
        chk("t1_busy_len", cnt, 19);

        // simultaneous requests from reset
        do_reset;
        dado_in = 16'h5678;
        instrucao_in = 16'h1234;
        req = 4'b1010;
        collect(2, '0, 100);
        if (gq.size() == 2) begin
            chk("t2_first", gq[0], 1);
            chk("t2_second", gq[1], 3);
            chk("t2_period", tq[1] - tq[0], 20);
        end

        // fairness
        do_reset;
        req = 4'b1111;
        collect(8, 4'b1111, 300);
`ifdef TX_ARBITRO_PRIO0_EN
        exp_seq = '{0, 0, 0, 0, 0, 0, 0, 0};
`else
        exp_seq = '{0, 1, 2, 3, 0, 1, 2, 3};
`endif
        if (gq.size() == 8)
            for (int k = 0; k < 8; k++) begin
                chk("t3_seq", gq[k], exp_seq[k]);
                if (k > 0) chk("t3_period", tq[k] - tq[k-1], 20);
            end
        chk("t3_frames", frames, 8);
        req = '0;
        repeat (25) tick;

        // dropped request during WAIT
        f0 = int'(frames);
        req = 4'b0001;
        collect(1, '0, 50);
        repeat (3) tick;
        req[1] = 1'b1;
        tick;
        req[1] = 1'b0;
        seen1 = 1'b0;
        for (int c = 0; c < 40; c++) begin
            tick;
            if (ack[1]) seen1 = 1'b1;
        end
        chk("t4_frames", frames, (f0 + 1) % 256);
        chk("t4_no_ack1", seen1, 0);

        // reset mid-frame at WAIT timer=5
        dado_in[11:8] = 4'hF;
        req = 4'b0100;
        tick;
        req = '0;
        repeat (6) tick;
        reset_n = 1'b0;
        #1;
        chk("t5_ocupado", ocupado, 0);
        chk("t5_dado", dado, 0);
        chk("t5_ack", ack, 0);
        tick;
        tick;
        reset_n = 1'b1;
        repeat (30) tick;
        chk("t5_frames", frames, 0);
        chk("t5_idle", ocupado, 0);

        // grant to 1, then 1101 pending
        do_reset;
        req = 4'b0010;
        collect(1, '0, 50);
        req = 4'b1101;
        collect(3, '0, 100);
`ifdef TX_ARBITRO_PRIO0_EN
        exp3 = '{0, 2, 3};
`else
        exp3 = '{2, 3, 0};
`endif
        if (gq.size() == 3)
            for (int k = 0; k < 3; k++) chk("t6_seq", gq[k], exp3[k]);

        // random traffic
        do_reset;
        for (int c = 0; c < 3000; c++) begin
            tick;
            for (int i = 0; i < N; i++) begin
                if (ack[i]) begin
                    req[i] = 1'b0;
                end else if (req[i]) begin
                    if ($urandom_range(63) == 0) req[i] = 1'b0;
                end else begin
                    dado_in[4*i +: 4] = 4'($urandom);
                    instrucao_in[4*i +: 4] = 4'($urandom);
                    if ($urandom_range(5) == 0) req[i] = 1'b1;
                end
            end
        end
        req = '0;
        repeat (25) tick;

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
